spike_ingress_arbiter: RTL and testbench

Multi-channel successor to the single-channel input spike-address path of the SNN core. It accepts spike events on `NUM_CH` independent channels and buffers each channel in its own FIFO. Each event is relocated by a per-channel base address, and the events are merged round-robin onto one valid/ready stream feeding the synapse fetch path. It also adds timestep-boundary draining and a selectable lossy or backpressure mode, neither of which the single-FIFO ingress has.

---
 rtl/spike_ingress_arbiter_pkg.sv | 21 ++
 rtl/spike_ingress_arbiter_if.sv | 28 ++
 rtl/spike_ingress_arbiter_ch_fifo.sv | 65 ++++++
 rtl/spike_ingress_arbiter.sv | 156 +++++++++++++++
 tb/tb_spike_ingress_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_ingress_arbiter_pkg.sv
// Shared types and helpers for the SNN spike ingress path.
package snn_pkg;

    localparam int unsigned SNN_ADDR_WIDTH = 14;

    typedef enum logic {
        TS_RUN   = 1'b0,
        TS_DRAIN = 1'b1
    } ts_state_t;

    // Smallest r with 2**r >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spike_ingress_arbiter_if.sv
// Handshake bundle of the spike ingress arbiter: per-channel event inputs and the merged output stream.
interface spike_ingress_arbiter_if
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ADDR_WIDTH = SNN_ADDR_WIDTH
);
    localparam int unsigned CH_W = clog2(NUM_CH);

    logic [NUM_CH-1:0]            i_ch_valid;
    logic [NUM_CH*ADDR_WIDTH-1:0] i_ch_addr;
    logic [NUM_CH-1:0]            o_ch_ready;
    logic                         o_out_valid;
    logic [ADDR_WIDTH-1:0]        o_out_addr;
    logic [CH_W-1:0]              o_out_ch;
    logic                         i_out_ready;

    modport slave (
        input  i_ch_valid, i_ch_addr, i_out_ready,
        output o_ch_ready, o_out_valid, o_out_addr, o_out_ch
    );

    modport master (
        output i_ch_valid, i_ch_addr, i_out_ready,
        input  o_ch_ready, o_out_valid, o_out_addr, o_out_ch
    );

endinterface

// File: rtl/spike_ingress_arbiter_ch_fifo.sv
// Per-channel spike address FIFO with registered full/empty flags.
module spike_ch_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only taken when the same cycle frees a slot.
    assign w_do_pop  = i_pop & ~r_empty;
    assign w_do_push = i_push & (~r_full | w_do_pop);

    always_comb begin
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/spike_ingress_arbiter.sv
// Multi-channel spike ingress: per-channel FIFOs, base relocation, round-robin merge,
// timestep-boundary drain and a saturating drop counter for lossy operation.
module spike_ingress_arbiter
    import snn_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ADDR_WIDTH   = SNN_ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned DROP_ON_FULL = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    spike_ingress_arbiter_if.slave       io_bus,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] i_ch_base,
    input  logic                         i_ts_end,
    output logic                         o_ts_done,
    output logic [CNT_WIDTH-1:0]         o_drop_cnt,
    input  logic                         i_clr_drop
);
    localparam int unsigned CH_W  = clog2(NUM_CH);
    localparam int unsigned POP_W = clog2(NUM_CH + 1);
    localparam bit          LOSSY = (DROP_ON_FULL != 0);

    ts_state_t             r_state;
    ts_state_t             w_state_nxt;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_push;
    logic [NUM_CH-1:0]     w_pop;
    logic [NUM_CH-1:0]     w_drop;
    logic [NUM_CH-1:0]     w_ready;
    logic [ADDR_WIDTH-1:0] w_fifo_data [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_base [NUM_CH];
    logic [ADDR_WIDTH-1:0] w_reloc;
    logic [CH_W-1:0]       r_rr_start;
    logic [CH_W-1:0]       w_grant_ch;
    logic [CH_W-1:0]       w_idx_ch;
    int unsigned           w_idx;
    logic                  w_grant_vld;
    logic                  w_load;
    logic                  w_drained;
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [CH_W-1:0]       r_out_ch;
    logic [CNT_WIDTH-1:0]  r_drop_cnt;
    logic [CNT_WIDTH:0]    w_drop_sum;
    logic [POP_W-1:0]      w_drop_pop;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_base[k] = i_ch_base[k*ADDR_WIDTH +: ADDR_WIDTH];

        spike_ch_fifo #(
            .WIDTH (ADDR_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[k]),
            .i_data  (io_bus.i_ch_addr[k*ADDR_WIDTH +: ADDR_WIDTH]),
            .i_pop   (w_pop[k]),
            .o_data  (w_fifo_data[k]),
            .o_full  (w_full[k]),
            .o_empty (w_empty[k])
        );
    end

    // Ready is zero outside RUN, so a full channel can only drop in lossy RUN.
    assign w_push = io_bus.i_ch_valid & w_ready & ~w_full;
    assign w_drop = io_bus.i_ch_valid & w_ready & w_full;

    assign w_load    = ~r_out_valid | io_bus.i_out_ready;
    assign w_drained = (&w_empty) & w_load;

    // Round-robin search beginning at the channel after the last grant.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_ch  = '0;
        w_idx       = 0;
        w_idx_ch    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_idx = 32'(r_rr_start) + i;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            w_idx_ch = w_idx[CH_W-1:0];
            if (!w_grant_vld && !w_empty[w_idx_ch]) begin
                w_grant_vld = 1'b1;
                w_grant_ch  = w_idx_ch;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        if (w_load && w_grant_vld) w_pop[w_grant_ch] = 1'b1;
    end

    assign w_reloc = w_fifo_data[w_grant_ch] + w_base[w_grant_ch];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_ch    <= '0;
            r_rr_start  <= '0;
        end else if (w_load) begin
            r_out_valid <= w_grant_vld;
            if (w_grant_vld) begin
                r_out_addr <= w_reloc;
                r_out_ch   <= w_grant_ch;
                r_rr_start <= (32'(w_grant_ch) == NUM_CH - 1) ? '0 : w_grant_ch + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= TS_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TS_RUN:   if (i_ts_end)  w_state_nxt = TS_DRAIN;
            TS_DRAIN: if (w_drained) w_state_nxt = TS_RUN;
            default:                 w_state_nxt = TS_RUN;
        endcase
    end

    always_comb begin
        w_ready   = '0;
        o_ts_done = 1'b0;
        if (!rst && r_state == TS_RUN) w_ready = LOSSY ? '1 : ~w_full;
        if (r_state == TS_DRAIN) o_ts_done = w_drained;
    end

    // Clear reloads with this cycle's drops so nothing is lost across a clear.
    always_comb begin
        w_drop_pop = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_drop_pop = w_drop_pop + POP_W'(w_drop[k]);
        end
        w_drop_sum = (i_clr_drop ? '0 : {1'b0, r_drop_cnt}) + (CNT_WIDTH + 1)'(w_drop_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_drop_cnt <= '0;
        else     r_drop_cnt <= w_drop_sum[CNT_WIDTH] ? '1 : w_drop_sum[CNT_WIDTH-1:0];
    end

    assign io_bus.o_ch_ready  = w_ready;
    assign io_bus.o_out_valid = r_out_valid;
    assign io_bus.o_out_addr  = r_out_addr;
    assign io_bus.o_out_ch    = r_out_ch;
    assign o_drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_spike_ingress_arbiter.sv
// Scoreboard bench for spike_ingress_arbiter: one backpressure-mode and one lossy-mode instance.
module tb_spike_ingress_arbiter;
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 14;
    localparam int unsigned CW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spike_ingress_arbiter_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) bp_if ();
    spike_ingress_arbiter_if #(.NUM_CH(NCH), .ADDR_WIDTH(AW)) lo_if ();

    logic [NCH*AW-1:0] bp_base, lo_base;
    logic              bp_ts_end, lo_ts_end, bp_ts_done, lo_ts_done, bp_clr, lo_clr;
    logic [CW-1:0]     bp_drop, lo_drop;

    spike_ingress_arbiter #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .FIFO_DEPTH(16), .CNT_WIDTH(CW), .DROP_ON_FULL(0)
    ) u_dut_bp (
        .clk(clk), .rst(rst), .io_bus(bp_if), .i_ch_base(bp_base), .i_ts_end(bp_ts_end),
        .o_ts_done(bp_ts_done), .o_drop_cnt(bp_drop), .i_clr_drop(bp_clr)
    );

    spike_ingress_arbiter #(
        .NUM_CH(NCH), .ADDR_WIDTH(AW), .FIFO_DEPTH(16), .CNT_WIDTH(CW), .DROP_ON_FULL(1)
    ) u_dut_lo (
        .clk(clk), .rst(rst), .io_bus(lo_if), .i_ch_base(lo_base), .i_ts_end(lo_ts_end),
        .o_ts_done(lo_ts_done), .o_drop_cnt(lo_drop), .i_clr_drop(lo_clr)
    );

    typedef struct packed {
        logic [1:0]    ch;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t         sb_q[$];
    logic [1:0]  ch_log[$];
    int unsigned n_checks = 0, n_errors = 0;
    int unsigned n_out_bp = 0, n_out_lo = 0, n_done_bp = 0, n_done_lo = 0;
    int unsigned n_out_at_done = 0, cyc = 0, first_out_cyc = 0, last_out_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted inputs push relocated addresses, output handshakes pop per channel.
    always @(negedge clk) begin
        int   hit_idx;
        ev_t  e;
        logic [AW-1:0] a, b;
        cyc++;
        if (!rst) begin
            if (bp_if.o_out_valid && bp_if.i_out_ready) begin
                n_out_bp++;
                last_out_cyc = cyc;
                ch_log.push_back(bp_if.o_out_ch);
                if (ch_log.size() == 1) first_out_cyc = cyc;
                hit_idx = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (hit_idx < 0 && sb_q[i].ch == bp_if.o_out_ch) hit_idx = i;
                end
                check("sb_hit", 32'(hit_idx >= 0), 1);
                if (hit_idx >= 0) begin
                    check("sb_addr", bp_if.o_out_addr, sb_q[hit_idx].addr);
                    sb_q.delete(hit_idx);
                end
            end
            for (int k = 0; k < NCH; k++) begin
                if (bp_if.i_ch_valid[k] && bp_if.o_ch_ready[k]) begin
                    a = bp_if.i_ch_addr[k*AW +: AW];
                    b = bp_base[k*AW +: AW];
                    e.ch   = 2'(k);
                    e.addr = a + b;
                    sb_q.push_back(e);
                end
            end
            if (bp_ts_done) begin
                n_done_bp++;
                n_out_at_done = n_out_bp;
            end
            if (lo_if.o_out_valid && lo_if.i_out_ready) n_out_lo++;
            if (lo_ts_done) n_done_lo++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sb_q.delete();
        ch_log.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_bp_empty(input string tag, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (sb_q.size() == 0 && !bp_if.o_out_valid) break;
            tick();
        end
        check(tag, sb_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned acc, base_out, base_done;
        bp_if.i_ch_valid = '0; bp_if.i_ch_addr = '0; bp_if.i_out_ready = 1'b1;
        lo_if.i_ch_valid = '0; lo_if.i_ch_addr = '0; lo_if.i_out_ready = 1'b1;
        bp_base = '0; lo_base = '0;
        bp_ts_end = 1'b0; lo_ts_end = 1'b0; bp_clr = 1'b0; lo_clr = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        tick();
        check("rst_ready_bp", bp_if.o_ch_ready, 0);
        check("rst_ready_lo", lo_if.o_ch_ready, 0);
        check("rst_valid", bp_if.o_out_valid, 0);
        check("rst_addr", bp_if.o_out_addr, 0);
        check("rst_ch", bp_if.o_out_ch, 0);
        check("rst_done", bp_ts_done, 0);
        check("rst_drop", lo_drop, 0);
        rst = 1'b0;
        tick();
        check("run_ready_bp", bp_if.o_ch_ready, 4'hF);
        check("run_ready_lo", lo_if.o_ch_ready, 4'hF);

        // Single event, idle output: two-cycle latency
        base_out = n_out_bp;
        bp_base[2*AW +: AW] = 14'h100;
        bp_if.i_ch_addr[2*AW +: AW] = 14'h005;
        bp_if.i_ch_valid = 4'b0100;
        tick();
        bp_if.i_ch_valid = '0;
        check("t1_not_yet", bp_if.o_out_valid, 0);
        tick();
        check("t1_valid", bp_if.o_out_valid, 1);
        check("t1_addr", bp_if.o_out_addr, 14'h105);
        check("t1_ch", bp_if.o_out_ch, 2);
        tick();
        check("t1_quiet", bp_if.o_out_valid, 0);
        repeat (3) tick();
        check("t1_count", n_out_bp - base_out, 1);

        // All channels every cycle: round-robin order and full throughput
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bp_if.i_ch_valid = 4'hF;
            for (int k = 0; k < NCH; k++) bp_if.i_ch_addr[k*AW +: AW] = 14'($urandom_range(0, 16383));
            tick();
        end
        bp_if.i_ch_valid = '0;
        wait_bp_empty("t2_drain", 200);
        check("t2_count", ch_log.size(), 48);
        for (int i = 0; i < 48 && i < ch_log.size(); i++) check("t2_order", ch_log[i], i % 4);
        check("t2_rate", last_out_cyc - first_out_cyc, 47);

        // Backpressure: ch0 fills its FIFO behind a stalled output register
        do_reset();
        bp_if.i_out_ready = 1'b0;
        bp_base[0*AW +: AW] = 14'h200;
        bp_base[1*AW +: AW] = 14'h040;
        bp_if.i_ch_addr[1*AW +: AW] = 14'h007;
        bp_if.i_ch_valid = 4'b0010;
        tick();
        bp_if.i_ch_valid = '0;
        tick();
        tick();
        check("t3_hold", bp_if.o_out_valid, 1);
        base_out = n_out_bp;
        acc = 0;
        for (int i = 0; i < 18; i++) begin
            bp_if.i_ch_valid = 4'b0001;
            bp_if.i_ch_addr[0*AW +: AW] = 14'(i * 3 + 1);
            check("t3_ready", bp_if.o_ch_ready[0], 32'(acc < 16));
            if (acc < 16) acc++;
            tick();
        end
        bp_if.i_ch_valid = '0;
        check("t3_hold_ch", bp_if.o_out_ch, 1);
        bp_if.i_out_ready = 1'b1;
        check("t3_full_same", bp_if.o_ch_ready[0], 0);
        tick();
        check("t3_full_next", bp_if.o_ch_ready[0], 1);
        wait_bp_empty("t3_drain", 100);
        check("t3_count", n_out_bp - base_out, 17);

        // Relocation wrap-around
        bp_base[3*AW +: AW] = 14'h3FF0;
        bp_if.i_ch_addr[3*AW +: AW] = 14'h0020;
        bp_if.i_ch_valid = 4'b1000;
        tick();
        bp_if.i_ch_valid = '0;
        tick();
        check("t4_valid", bp_if.o_out_valid, 1);
        check("t4_addr", bp_if.o_out_addr, 14'h0010);
        check("t4_ch", bp_if.o_out_ch, 3);
        tick();

        // Timestep drain with 3 buffered events and a 5-cycle stall
        bp_if.i_out_ready = 1'b0;
        bp_if.i_ch_valid = 4'b0111;
        tick();
        bp_if.i_ch_valid = '0;
        tick();
        tick();
        base_out  = n_out_bp;
        base_done = n_done_bp;
        bp_ts_end = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bp_ts_end = (i == 2);
            check("t5_no_accept", bp_if.o_ch_ready, 0);
            check("t5_no_done", bp_ts_done, 0);
            tick();
        end
        bp_ts_end = 1'b0;
        bp_if.i_out_ready = 1'b1;
        repeat (20) tick();
        check("t5_done_once", n_done_bp - base_done, 1);
        check("t5_done_after_last", n_out_at_done - base_out, 3);
        check("t5_ready_back", bp_if.o_ch_ready, 4'hF);
        bp_ts_end = 1'b1;
        tick();
        bp_ts_end = 1'b0;
        check("t5_early_done", bp_ts_done, 1);
        check("t5_early_ready", bp_if.o_ch_ready, 0);
        tick();
        check("t5_early_clear", bp_ts_done, 0);

        // Asynchronous reset mid-operation discards buffered events
        bp_if.i_out_ready = 1'b0;
        bp_if.i_ch_valid = 4'hF;
        tick();
        bp_if.i_ch_valid = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", bp_if.o_out_valid, 0);
        check("t6_rst_ready", bp_if.o_ch_ready, 0);
        sb_q.delete();
        base_out = n_out_bp;
        tick();
        rst = 1'b0;
        bp_if.i_out_ready = 1'b1;
        repeat (6) tick();
        check("t6_flushed", n_out_bp - base_out, 0);
        check("t6_ready", bp_if.o_ch_ready, 4'hF);

        // Lossy mode: drops, clear-with-drop, no drops while draining
        lo_if.i_out_ready = 1'b0;
        lo_if.i_ch_valid = 4'b0001;
        tick();
        lo_if.i_ch_valid = '0;
        tick();
        tick();
        check("t7_hold", lo_if.o_out_valid, 1);
        for (int i = 0; i < 20; i++) begin
            lo_if.i_ch_valid = 4'b0010;
            lo_if.i_ch_addr[1*AW +: AW] = 14'(i);
            check("t7_ready", lo_if.o_ch_ready[1], 1);
            tick();
        end
        lo_if.i_ch_valid = '0;
        check("t7_drop4", lo_drop, 4);
        for (int i = 0; i < 16; i++) begin
            lo_if.i_ch_valid = 4'b1000;
            tick();
        end
        lo_if.i_ch_valid = '0;
        check("t7_drop_still4", lo_drop, 4);
        lo_if.i_ch_valid = 4'b1010;
        lo_clr = 1'b1;
        tick();
        lo_if.i_ch_valid = '0;
        lo_clr = 1'b0;
        check("t7_clr_drop2", lo_drop, 2);
        lo_clr = 1'b1;
        tick();
        lo_clr = 1'b0;
        check("t7_clr_zero", lo_drop, 0);
        base_out  = n_out_lo;
        base_done = n_done_lo;
        lo_ts_end = 1'b1;
        tick();
        lo_ts_end = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lo_if.i_ch_valid = 4'b0010;
            check("t7_drain_ready", lo_if.o_ch_ready, 0);
            tick();
        end
        lo_if.i_ch_valid = '0;
        check("t7_drain_nodrop", lo_drop, 0);
        lo_if.i_out_ready = 1'b1;
        repeat (60) tick();
        check("t7_outs", n_out_lo - base_out, 33);
        check("t7_done", n_done_lo - base_done, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
